sprite_line_fetcher: RTL and testbench

SPRITE_LINE_FETCHER -- requirements
Module: sprite_line_fetcher

---
 rtl/sprite_line_fetcher.sv | 168 ++++++++++++++++
 tb/tb_sprite_line_fetcher.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_fetcher.sv
// Sprite scanline fetcher: on line_start, tests whether the requested scanline
// crosses the sprite, streams that sprite row out of a 1-cycle-latency ROM
// into a line buffer, then serves per-column pixels with colour-key masking.
//
// Ports:
//   Clk, Reset_n            clock, async active-low reset
//   line_start, line_y      fetch request pulse and scanline
//   sprite_x, sprite_y      sprite top-left position (sampled on line_start)
//   flip_h, flip_v          mirror flags (sampled on line_start)
//   rom_addr / rom_data     sprite ROM read port (data valid one cycle later)
//   draw_x                  column being displayed
//   pixel_rgb, pixel_valid  sprite colour for previous cycle's draw_x
//   line_ready, busy        line buffer complete / fetch in progress
module sprite_line_fetcher #(
  parameter int unsigned SPR_DIM   = 26,
  parameter logic [23:0] KEY_COLOR = 24'h000000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        line_start,
  input  logic [9:0]  line_y,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        flip_h,
  input  logic        flip_v,
  output logic [9:0]  rom_addr,
  input  logic [23:0] rom_data,
  input  logic [9:0]  draw_x,
  output logic [23:0] pixel_rgb,
  output logic        pixel_valid,
  output logic        line_ready,
  output logic        busy
);

  localparam int unsigned IDX_W  = $clog2(SPR_DIM);
  localparam int unsigned CRD_W  = 10;
  localparam int unsigned CMP_W  = CRD_W + 1;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned PIX_W  = 24;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPR_DIM - 1);
  localparam logic [CMP_W-1:0] SPAN     = CMP_W'(SPR_DIM - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_e;

  state_e             state_q;
  logic               hit_q;
  logic [IDX_W-1:0]   row_q;
  logic [IDX_W-1:0]   col_q;
  logic               flip_h_q;
  logic [CRD_W-1:0]   sprite_x_q;
  logic [ADDR_W-1:0]  rom_addr_q;
  logic [PIX_W-1:0]   pixel_rgb_q;
  logic               pixel_valid_q;
  logic               line_ready_q;
  logic               busy_q;
  logic [PIX_W-1:0]   linebuf_q [SPR_DIM];

  // ROM address for a buffer column; the mirror only affects the source column.
  function automatic logic [ADDR_W-1:0] calc_addr(input logic [IDX_W-1:0] row,
                                                  input logic [IDX_W-1:0] col,
                                                  input logic             fh);
    logic [IDX_W-1:0] src;
    src = fh ? (LAST_IDX - col) : col;
    return ADDR_W'(row) * ADDR_W'(SPR_DIM) + ADDR_W'(src);
  endfunction

  // Vertical hit test and row select, widened so sprite_y+SPR_DIM cannot wrap.
  logic [CMP_W-1:0] line_y_w, sprite_y_w, dy_w;
  logic             hit_d;
  logic [IDX_W-1:0] row_d;
  assign line_y_w   = {1'b0, line_y};
  assign sprite_y_w = {1'b0, sprite_y};
  assign dy_w       = line_y_w - sprite_y_w;
  assign hit_d      = (line_y_w >= sprite_y_w) && (line_y_w <= sprite_y_w + SPAN);
  assign row_d      = flip_v ? (LAST_IDX - IDX_W'(dy_w)) : IDX_W'(dy_w);

  // Horizontal window lookup for the pixel path.
  logic [CMP_W-1:0] draw_x_w, sprite_x_w, dx_w;
  logic             in_rng_c;
  logic [IDX_W-1:0] rd_idx_c;
  logic [PIX_W-1:0] rd_pix_c;
  logic             pix_ok_c;
  assign draw_x_w   = {1'b0, draw_x};
  assign sprite_x_w = {1'b0, sprite_x_q};
  assign dx_w       = draw_x_w - sprite_x_w;
  assign in_rng_c   = (draw_x_w >= sprite_x_w) && (draw_x_w <= sprite_x_w + SPAN);
  assign rd_idx_c   = in_rng_c ? IDX_W'(dx_w) : '0;
  assign rd_pix_c   = linebuf_q[rd_idx_c];
  // A line_start this cycle leaves READY, so the next pixel must already be blank.
  assign pix_ok_c   = (state_q == READY) && hit_q && !line_start && in_rng_c &&
                      (rd_pix_c != KEY_COLOR);

  // ROM data returning now belongs to the column issued one cycle earlier.
  logic             wr_en_c;
  logic [IDX_W-1:0] wr_idx_c;
  assign wr_en_c  = ((state_q == FETCH) && (col_q != '0)) || (state_q == DRAIN);
  assign wr_idx_c = (state_q == DRAIN) ? LAST_IDX : (col_q - IDX_W'(1));

  // Line buffer storage; contents are meaningless until a fetch completes.
  always_ff @(posedge Clk) begin
    if (wr_en_c) linebuf_q[wr_idx_c] <= rom_data;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      hit_q         <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      flip_h_q      <= 1'b0;
      sprite_x_q    <= '0;
      rom_addr_q    <= '0;
      pixel_rgb_q   <= '0;
      pixel_valid_q <= 1'b0;
      line_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      pixel_valid_q <= pix_ok_c;
      pixel_rgb_q   <= pix_ok_c ? rd_pix_c : '0;
      // A request in any state (including mid-fetch) restarts from scratch.
      if (line_start) begin
        hit_q      <= 1'b0;
        row_q      <= row_d;
        col_q      <= '0;
        flip_h_q   <= flip_h;
        sprite_x_q <= sprite_x;
        if (hit_d) begin
          state_q      <= FETCH;
          rom_addr_q   <= calc_addr(row_d, '0, flip_h);
          busy_q       <= 1'b1;
          line_ready_q <= 1'b0;
        end else begin
          state_q      <= READY;
          rom_addr_q   <= '0;
          busy_q       <= 1'b0;
          line_ready_q <= 1'b1;
        end
      end else begin
        case (state_q)
          FETCH: begin
            if (col_q == LAST_IDX) begin
              state_q    <= DRAIN;
              rom_addr_q <= '0;
            end else begin
              col_q      <= col_q + IDX_W'(1);
              rom_addr_q <= calc_addr(row_q, col_q + IDX_W'(1), flip_h_q);
            end
          end
          DRAIN: begin
            state_q      <= READY;
            hit_q        <= 1'b1;
            busy_q       <= 1'b0;
            line_ready_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rom_addr    = rom_addr_q;
  assign pixel_rgb   = pixel_rgb_q;
  assign pixel_valid = pixel_valid_q;
  assign line_ready  = line_ready_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Scoreboard bench for sprite_line_fetcher with a behavioural 1-cycle ROM.
module tb_sprite_line_fetcher;

  localparam int SPR = 26;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        line_start;
  logic [9:0]  line_y, sprite_x, sprite_y;
  logic        flip_h, flip_v;
  logic [9:0]  rom_addr;
  logic [23:0] rom_data;
  logic [9:0]  draw_x;
  logic [23:0] pixel_rgb;
  logic        pixel_valid, line_ready, busy;

  sprite_line_fetcher #(.SPR_DIM(SPR), .KEY_COLOR(24'h000000)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .line_start(line_start), .line_y(line_y),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .flip_h(flip_h), .flip_v(flip_v),
    .rom_addr(rom_addr), .rom_data(rom_data), .draw_x(draw_x),
    .pixel_rgb(pixel_rgb), .pixel_valid(pixel_valid), .line_ready(line_ready),
    .busy(busy)
  );

  always #5 Clk = ~Clk;

  logic [23:0] rom [SPR*SPR];
  always @(posedge Clk) rom_data <= rom[rom_addr];

  int          errors = 0;
  int          checks = 0;
  int          addr_q[$];
  logic [24:0] pix_q[$];
  logic [23:0] exp_lb [SPR];
  bit          tb_hit;
  int          tb_sx;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pulse line_start in the current cycle; push the expected address stream.
  task automatic do_line(input int ly, input int sy, input int sx, input bit fh, input bit fv);
    int row, a;
    line_y     = 10'(ly);
    sprite_y   = 10'(sy);
    sprite_x   = 10'(sx);
    flip_h     = fh;
    flip_v     = fv;
    line_start = 1'b1;
    tb_hit     = (ly >= sy) && (ly <= sy + SPR - 1);
    tb_sx      = sx;
    if (tb_hit) begin
      row = ly - sy;
      if (fv) row = SPR - 1 - row;
      for (int c = 0; c < SPR; c++) begin
        a = row * SPR + (fh ? (SPR - 1 - c) : c);
        addr_q.push_back(a);
        exp_lb[c] = rom[a];
      end
    end
    @(negedge Clk);
    line_start = 1'b0;
    sprite_x   = 10'(sx + 300);
  endtask

  task automatic fetch_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check("rom_addr", 32'(rom_addr), 32'(addr_q.pop_front()));
      check("busy_fetch", 32'(busy), 32'd1);
      check("ready_fetch", 32'(line_ready), 32'd0);
      check("pvalid_fetch", 32'(pixel_valid), 32'd0);
      @(negedge Clk);
    end
  endtask

  task automatic finish_fetch();
    check("busy_drain", 32'(busy), 32'd1);
    check("addr_drain", 32'(rom_addr), 32'd0);
    check("ready_drain", 32'(line_ready), 32'd0);
    @(negedge Clk);
    check("ready_done", 32'(line_ready), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("addr_done", 32'(rom_addr), 32'd0);
  endtask

  task automatic pix_check(input int dx);
    bit          in_rng, v;
    logic [23:0] px;
    logic [24:0] got, exp;
    draw_x = 10'(dx);
    in_rng = (dx >= tb_sx) && (dx <= tb_sx + SPR - 1);
    px     = in_rng ? exp_lb[dx - tb_sx] : 24'h0;
    v      = tb_hit && in_rng && (px != 24'h0);
    pix_q.push_back({v, v ? px : 24'h0});
    @(negedge Clk);
    got = {pixel_valid, pixel_rgb};
    exp = pix_q.pop_front();
    check("pixel", 32'(got), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < SPR * SPR; i++)
      rom[i] = {8'(i), 8'(i >> 8) | 8'h40, 8'(255 - (i & 255))};
    rom[78] = 24'hFFFF00;
    rom[80] = 24'h000000;
    Reset_n = 1'b0; line_start = 1'b0; line_y = '0; sprite_x = '0; sprite_y = '0;
    flip_h = 1'b0; flip_v = 1'b0; draw_x = '0; tb_hit = 1'b0; tb_sx = 0;
    for (int c = 0; c < SPR; c++) exp_lb[c] = '0;

    repeat (2) @(negedge Clk);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_rgb", 32'(pixel_rgb), 32'd0);
    check("rst_valid", 32'(pixel_valid), 32'd0);
    check("rst_ready", 32'(line_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Plain hit, then pixel readout including key colour and window edges.
    do_line(103, 100, 200, 1'b0, 1'b0);
    fetch_cycles(SPR);
    finish_fetch();
    pix_check(200);
    pix_check(202);
    pix_check(201);
    pix_check(225);
    pix_check(226);
    pix_check(199);
    check("word78", 32'(exp_lb[0]), 32'h00FFFF00);

    // Both mirrors: row 22, addresses 597 down to 572.
    do_line(103, 100, 200, 1'b1, 1'b1);
    fetch_cycles(SPR);
    finish_fetch();
    pix_check(200);
    pix_check(225);

    // Miss: ready at once, no ROM traffic, no pixels.
    do_line(99, 100, 200, 1'b0, 1'b0);
    check("miss_ready", 32'(line_ready), 32'd1);
    check("miss_busy", 32'(busy), 32'd0);
    check("miss_addr", 32'(rom_addr), 32'd0);
    pix_check(200);
    check("miss_addr2", 32'(rom_addr), 32'd0);
    pix_check(210);

    // Abort: second request in cycle 10 restarts on row 4.
    do_line(103, 100, 200, 1'b0, 1'b0);
    fetch_cycles(9);
    addr_q.delete();
    do_line(104, 100, 200, 1'b0, 1'b0);
    fetch_cycles(SPR);
    finish_fetch();
    pix_check(200);
    pix_check(213);

    // Asynchronous reset in cycle 15 of a fetch.
    do_line(103, 100, 200, 1'b0, 1'b0);
    fetch_cycles(14);
    addr_q.delete();
    check("pre_rst_addr", 32'(rom_addr), 32'd92);
    Reset_n = 1'b0;
    #1;
    check("arst_addr", 32'(rom_addr), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(line_ready), 32'd0);
    check("arst_valid", 32'(pixel_valid), 32'd0);
    check("arst_rgb", 32'(pixel_rgb), 32'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 35; i++) begin
      @(negedge Clk);
      check("idle_ready", 32'(line_ready), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // Edge: sprite near the bottom of the 10-bit range; no wrap in compares.
    do_line(1023, 1000, 1010, 1'b0, 1'b0);
    check("edge_first", 32'(rom_addr), 32'd598);
    fetch_cycles(SPR);
    finish_fetch();
    pix_check(1023);
    pix_check(1009);
    pix_check(1010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
